// File: rtl/uart_scope_pkg.sv
// Shared definitions for the uart_scope control path: frame constants,
// command parser state encoding and the scope register address map.
package uart_scope_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    localparam int unsigned FRAME_LEN_NOCHK = 4;
    localparam int unsigned FRAME_LEN_CHK   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DAT_H,
        ST_DAT_L,
        ST_CHK
    } parser_state_t;

    localparam logic [7:0] REG_TRIG_LEVEL = 8'h00;
    localparam logic [7:0] REG_TRIG_CTRL  = 8'h01;
    localparam logic [7:0] REG_TIMEBASE   = 8'h02;
    localparam logic [7:0] REG_CAP_DEPTH  = 8'h03;
    localparam logic [7:0] REG_CH_ENABLE  = 8'h10;

    function automatic logic [7:0] frame_checksum(input logic [7:0] a,
                                                  input logic [7:0] h,
                                                  input logic [7:0] l);
        return a + h + l;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter: saturates at TIMEOUT_CYC-1 and raises expire
// combinationally while enabled and not being cleared.
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned    CW      = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = en && !clr && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_cmd_parser.sv
// Command frame decoder behind the UART receiver; issues register writes.
// Optional checksum byte enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_parser
    import uart_scope_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  SOF_BYTE    = SOF_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    output logic        frame_err,
    output logic        busy
);

    parser_state_t state, state_nxt;

    logic [7:0] addr_sh;
    logic [7:0] dh_sh;
    logic [7:0] commit_lo;
    logic       ld_addr, ld_dh;
    logic       commit, drop;
    logic       expire;
    logic       in_idle;

    assign in_idle = (state == ST_IDLE);
    assign busy    = !in_idle;

    uart_cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_done || in_idle),
        .en     (!in_idle),
        .expire (expire)
    );

`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] dl_sh;
    logic       ld_dl;

    assign commit_lo = dl_sh;
`else
    // Without a checksum byte the low data byte commits straight from the bus.
    assign commit_lo = rx_byte;
`endif

    always_comb begin
        state_nxt = state;
        ld_addr   = 1'b0;
        ld_dh     = 1'b0;
        commit    = 1'b0;
        drop      = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        ld_dl     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (rx_done && (rx_byte == SOF_BYTE)) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_done) begin
                    ld_addr   = 1'b1;
                    state_nxt = ST_DAT_H;
                end
            end
            ST_DAT_H: begin
                if (rx_done) begin
                    ld_dh     = 1'b1;
                    state_nxt = ST_DAT_L;
                end
            end
            ST_DAT_L: begin
                if (rx_done) begin
`ifdef UART_CMD_CHECKSUM_EN
                    ld_dl     = 1'b1;
                    state_nxt = ST_CHK;
`else
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CHK: begin
                if (rx_done) begin
                    if (rx_byte == frame_checksum(addr_sh, dh_sh, dl_sh)) begin
                        commit = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
        // expire is already masked by rx_done, so a byte on the expiry cycle wins.
        if (expire) begin
            drop      = 1'b1;
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_sh <= '0;
            dh_sh   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            dl_sh   <= '0;
`endif
        end else if (expire) begin
            addr_sh <= '0;
            dh_sh   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            dl_sh   <= '0;
`endif
        end else begin
            if (ld_addr) addr_sh <= rx_byte;
            if (ld_dh)   dh_sh   <= rx_byte;
`ifdef UART_CMD_CHECKSUM_EN
            if (ld_dl)   dl_sh   <= rx_byte;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            reg_wr    <= commit;
            frame_err <= drop;
            if (commit) begin
                reg_addr  <= addr_sh;
                reg_wdata <= {dh_sh, commit_lo};
            end
        end
    end

endmodule
